// File: rtl/rk4_uart_pkg.sv
// Shared types for the RK4 projectile UART link: Q16.16 word type, receiver
// FSM states, and the end-of-stream marker shared with the transmit side.
package rk4_uart_pkg;

  typedef logic signed [31:0] q16_16_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam q16_16_t EOS_MARKER = 32'hDEADBEEF;

endpackage

// File: rtl/uart_word_rx_if.sv
// Word delivery handshake between the UART receiver and the RK4 control FSM.
interface uart_word_rx_if;
  import rk4_uart_pkg::*;

  q16_16_t word_data;
  logic    word_valid;
  logic    word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF line synchronizer, mid-bit sampling, byte FSM.
// byte_valid / frame_err are single-cycle strobes in the stop-sample cycle.
module uart_rx_byte
  import rk4_uart_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       idle
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic          rx_s;
  logic          fall;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;

  assign rx_s = sync_q[1];
  assign fall = rx_prev_q && !rx_s;

  // Sync flops preset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          state_d    = IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data = sh_q;
  assign idle = (state_q == IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// UART 8N1 word receiver: assembles 4 bytes little-endian into a Q16.16 word
// with valid/ready delivery. Optional inter-byte timeout: UART_RX_TIMEOUT_EN.
module uart_word_rx
  import rk4_uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  uart_word_rx_if.master word_if,
  output logic frame_err,
  output logic overrun,
  output logic rx_timeout,
  output logic busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;

  if (BAUD_DIV < 4 || TIMEOUT_BITS < 1) begin : g_cfg_check
    $error("uart_word_rx: BAUD_DIV must be >= 4 and TIMEOUT_BITS >= 1");
  end

  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ferr;
  logic        b_idle;
  logic [1:0]  idx_q;
  logic [23:0] lanes_q;
  logic        complete;
  logic        fire;
  logic        to_hit;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .data       (b_data),
    .byte_valid (b_valid),
    .frame_err  (b_ferr),
    .idle       (b_idle)
  );

  assign complete = b_valid && (idx_q == 2'd3);
  assign fire     = word_if.word_valid && word_if.word_ready;
  assign busy     = !b_idle || (idx_q != 2'd0);

  // NOTE: lane storage is data-only and always overwritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (b_valid) begin
      unique case (idx_q)
        2'd0:    lanes_q[7:0]   <= b_data;
        2'd1:    lanes_q[15:8]  <= b_data;
        2'd2:    lanes_q[23:16] <= b_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q              <= 2'd0;
      word_if.word_data  <= '0;
      word_if.word_valid <= 1'b0;
      frame_err          <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      frame_err <= b_ferr;
      overrun   <= 1'b0;
      if (b_ferr || to_hit) idx_q <= 2'd0;
      else if (b_valid)     idx_q <= idx_q + 2'd1;
      // A completed word may replace the held one only if it leaves this edge.
      if (complete) begin
        if (!word_if.word_valid || word_if.word_ready) begin
          word_if.word_data  <= {b_data, lanes_q};
          word_if.word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (fire) begin
        word_if.word_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CLKS = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW      = $clog2(TO_CLKS);

  logic [TW-1:0] to_cnt_q;
  logic          to_run;

  // Leaving IDLE (a start bit) also clears the counter.
  assign to_run = b_idle && (idx_q != 2'd0);
  assign to_hit = to_run && (to_cnt_q == TW'(TO_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= to_hit;
      if (!to_run || to_hit) to_cnt_q <= '0;
      else                   to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit     = 1'b0;
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: byte-level reference model predicts words
// and event counts; a negedge monitor checks every handshake and pulse.
module tb_uart_word_rx;
  import rk4_uart_pkg::*;

  localparam int BAUD_DIV = 10;
  localparam int TO_BITS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic frame_err, overrun, rx_timeout, busy;

  uart_word_rx_if w_if ();

  uart_word_rx #(
    .CLK_FREQ     (50_000_000),
    .BAUD_RATE    (5_000_000),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .word_if    (w_if),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_timeout (rx_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] sb[$];
  logic [7:0]  acc[$];
  int exp_ferr = 0, got_ferr = 0;
  int exp_ovr  = 0, got_ovr  = 0;
  int exp_to   = 0, got_to   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: bytes accumulate; a bad stop bit discards the partial
  // word; every 4th good byte forms {b3,b2,b1,b0}. A word completing while an
  // earlier one is still undelivered and ready is low is an overrun.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin
      exp_ferr++;
      acc.delete();
    end else begin
      acc.push_back(b);
      if (acc.size() == 4) begin
        w = {acc[3], acc[2], acc[1], acc[0]};
        if (!w_if.word_ready && sb.size() != 0) exp_ovr++;
        else sb.push_back(w);
        acc.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    model_byte(b, stop_ok);
    uart_rx = 1'b0;
    tick(BAUD_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BAUD_DIV);
    end
    uart_rx = stop_ok;
    tick(BAUD_DIV);
    uart_rx = 1'b1;
    if (!stop_ok) tick(BAUD_DIV);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap = 0);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[8*i +: 8]);
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 2000) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d words never delivered", sb.size());
      sb.delete();
    end
    tick(3);
  endtask

  task automatic check_events(input string tag);
    check({tag, "_ferr_cnt"}, got_ferr, exp_ferr);
    check({tag, "_ovr_cnt"}, got_ovr, exp_ovr);
    check({tag, "_to_cnt"}, got_to, exp_to);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks data stability
  // while held, and that valid drops the cycle after a handshake.
  bit          fired_last = 1'b0;
  bit          holding = 1'b0;
  logic [31:0] held;

  always @(negedge clk) begin
    if (rst) begin
      fired_last = 1'b0;
      holding    = 1'b0;
    end else begin
      if (frame_err)  got_ferr++;
      if (overrun)    got_ovr++;
      if (rx_timeout) got_to++;
      if (fired_last) check("valid_drop", {31'd0, w_if.word_valid}, 32'd0);
      if (holding && w_if.word_valid) check("data_stable", w_if.word_data, held);
      fired_last = w_if.word_valid && w_if.word_ready;
      if (fired_last) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL word: got %h expected none", w_if.word_data);
        end else begin
          check("word", w_if.word_data, sb.pop_front());
        end
      end
      holding = w_if.word_valid && !w_if.word_ready;
      held    = w_if.word_data;
    end
  end

  initial begin
    logic [31:0] w1, w2;
    int k;
    w_if.word_ready = 1'b1;
    tick(4);
    check("rst_valid", {31'd0, w_if.word_valid}, 32'd0);
    check("rst_data", w_if.word_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {29'd0, frame_err, overrun, rx_timeout}, 32'd0);
    rst = 1'b0;
    tick(5);

    // 1: v0y = 49.0
    send_word(32'h00310000);
    wait_drain();
    check_events("t1");

    // 2: v0y = 19.6 held for 50 clocks
    w_if.word_ready = 1'b0;
    send_word(32'h00139999);
    k = 0;
    while (!w_if.word_valid && k < 200) begin
      tick();
      k++;
    end
    tick(50);
    check("t2_valid_held", {31'd0, w_if.word_valid}, 32'd1);
    w_if.word_ready = 1'b1;
    wait_drain();
    check_events("t2");

    // 3: short glitch is ignored, then the end-of-stream marker
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    check("t3_busy_after_glitch", {31'd0, busy}, 32'd0);
    send_word(EOS_MARKER);
    wait_drain();
    check_events("t3");

    // 4: third byte has a bad stop bit
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    send_byte(8'($urandom), 1'b0);
    send_word(32'h44332211);
    wait_drain();
    check_events("t4");

    // 5: two words back to back while not ready
    w1 = $urandom;
    w2 = $urandom;
    w_if.word_ready = 1'b0;
    send_word(w1);
    send_word(w2);
    tick(5);
    check_events("t5_held");
    w_if.word_ready = 1'b1;
    wait_drain();
    check_events("t5");

    // Random words with random inter-byte gaps below the timeout
    for (int i = 0; i < 8; i++) send_word($urandom, int'($urandom_range(0, 60)));
    wait_drain();
    check_events("rand");

    // Reset in the middle of a word and a byte
    send_byte(8'hA5);
    send_byte(8'h5A);
    uart_rx = 1'b0;
    tick(15);
    rst = 1'b1;
    acc.delete();
    tick(2);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, w_if.word_valid}, 32'd0);
    check("mid_rst_data", w_if.word_data, 32'd0);
    uart_rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    send_word(32'hCAFE0042);
    wait_drain();
    check_events("mid_rst");

    // 6: partial word followed by a long idle gap
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(20 * BAUD_DIV);
`ifdef UART_RX_TIMEOUT_EN
    exp_to++;
    acc.delete();
    check("t6_busy", {31'd0, busy}, 32'd0);
`else
    check("t6_busy", {31'd0, busy}, 32'd1);
`endif
    send_word(32'h04030201);
    wait_drain();
    check_events("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
